// File: rtl/count_game_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_game_if : control/status link between count_game_ctrl and the counter
// Rev 1.0
// ---------------------------------------------------------------------------
interface count_game_if;
  logic       clear;
  logic       init;
  logic [3:0] initial_value;
  logic [1:0] control;
  logic       gameover;
  logic [1:0] who;

  modport master (output clear, init, initial_value, control, input gameover, who);
  modport slave  (input clear, init, initial_value, control, output gameover, who);
endinterface
`default_nettype wire

// File: rtl/count_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_game_ctrl : drives the up/down counting game over N rounds and tallies
//                   winner/loser/timeout results. Option: COUNT_GAME_LFSR_INIT_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module count_game_ctrl #(
  parameter int STEP_CYCLES = 4,
  parameter int TIMEOUT     = 1023,
  parameter int RND_W       = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic             abort,
  input  wire logic [RND_W-1:0] cfg_rounds,
  input  wire logic [3:0]       cfg_init,
  input  wire logic [7:0]       cfg_prog,
  count_game_if.master          ctr,
  output logic                  busy,
  output logic                  done,
  output logic [RND_W-1:0]      wins,
  output logic [RND_W-1:0]      losses,
  output logic [RND_W-1:0]      timeouts,
  output logic [1:0]            last_who
);
  localparam int HOLD_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] c_HOLD_MAX  = HOLD_W'(STEP_CYCLES - 1);
  localparam logic [WD_W-1:0]   c_WD_MAX    = WD_W'(TIMEOUT);
  localparam logic [RND_W-1:0]  c_TALLY_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD   = 3'd2,
    S_RUN    = 3'd3,
    S_RECORD = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t            r_state, w_next;
  logic [RND_W-1:0]  r_rounds, r_round, r_wins, r_losses, r_touts;
  logic [7:0]        r_prog;
  logic [1:0]        r_step, w_step_nxt, r_cap, r_control, r_last;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [WD_W-1:0]   r_wdog, w_wdog_nxt;
  logic [3:0]        r_iv, w_load_val;
  logic              r_clear, r_initl, r_busy, r_done;
  logic              w_accept, w_last_round;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_last_round = ((r_round + 1'b1) == r_rounds);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_step_nxt = r_step;
    w_hold_nxt = r_hold;
    w_wdog_nxt = r_wdog;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CLR;
      S_CLR:    w_next = S_LOAD;
      S_LOAD: begin
        w_step_nxt = 2'd0;
        w_hold_nxt = '0;
        w_wdog_nxt = '0;
        w_next     = S_RUN;
      end
      S_RUN: begin
        w_wdog_nxt = r_wdog + 1'b1;
        if (r_hold == c_HOLD_MAX) begin
          w_step_nxt = r_step + 2'd1;
          w_hold_nxt = '0;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
        // RUN lasts at most TIMEOUT cycles: exit on the cycle the count reaches it
        if (ctr.gameover || abort || (w_wdog_nxt == c_WD_MAX)) w_next = S_RECORD;
      end
      S_RECORD: w_next = (abort || w_last_round) ? S_FIN : S_CLR;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

`ifdef COUNT_GAME_LFSR_INIT_EN
  logic [3:0] r_lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_lfsr <= 4'h1;
    else if (w_accept)          r_lfsr <= (cfg_init == 4'h0) ? 4'h1 : cfg_init;
    else if (w_next == S_LOAD)  r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  end
  assign w_load_val = r_lfsr;
`else
  logic [3:0] r_init;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_init <= 4'h0;
    else if (w_accept) r_init <= cfg_init;
  end
  assign w_load_val = r_init;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clear <= 1'b0;  r_initl <= 1'b0;  r_iv <= 4'h0;  r_control <= 2'b00;
      r_busy  <= 1'b0;  r_done  <= 1'b0;
      r_wins  <= '0;    r_losses <= '0;   r_touts <= '0; r_last <= 2'b00;
      r_rounds <= '0;   r_round <= '0;    r_prog <= 8'h00; r_cap <= 2'b00;
      r_step  <= 2'd0;  r_hold <= '0;     r_wdog <= '0;
    end else begin
      // outputs are registered from the next state so they line up with it
      r_clear   <= (w_next == S_CLR);
      r_initl   <= (w_next == S_LOAD);
      r_iv      <= (w_next == S_LOAD) ? w_load_val : 4'h0;
      r_control <= (w_next == S_RUN) ? r_prog[{w_step_nxt, 1'b0} +: 2] : 2'b00;
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_FIN);
      r_step    <= w_step_nxt;
      r_hold    <= w_hold_nxt;
      r_wdog    <= w_wdog_nxt;
      if (w_accept) begin
        r_rounds <= (cfg_rounds == '0) ? RND_W'(1) : cfg_rounds;
        r_prog   <= cfg_prog;
        r_round  <= '0;
        r_wins   <= '0;
        r_losses <= '0;
        r_touts  <= '0;
        r_last   <= 2'b00;
      end
      if (r_state == S_RUN) r_cap <= ctr.gameover ? ctr.who : 2'b11;
      if (r_state == S_RECORD) begin
        case (r_cap)
          2'b10:   if (r_wins   != c_TALLY_MAX) r_wins   <= r_wins   + 1'b1;
          2'b01:   if (r_losses != c_TALLY_MAX) r_losses <= r_losses + 1'b1;
          default: if (r_touts  != c_TALLY_MAX) r_touts  <= r_touts  + 1'b1;
        endcase
        r_last  <= r_cap;
        r_round <= r_round + 1'b1;
      end
    end
  end

  assign ctr.clear         = r_clear;
  assign ctr.init          = r_initl;
  assign ctr.initial_value = r_iv;
  assign ctr.control       = r_control;
  assign busy              = r_busy;
  assign done              = r_done;
  assign wins              = r_wins;
  assign losses            = r_losses;
  assign timeouts          = r_touts;
  assign last_who          = r_last;
endmodule
`default_nettype wire
